// File: rtl/apb_interrupt_controller_pkg.sv
// Shared definitions for the APB interrupt controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package apb_interrupt_controller_pkg;

  // Default number of interrupt sources
  localparam int NUM_PERIPHS_DEF = 16;

  // Interrupt FSM encoding, kept as plain constants for legacy tools
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

endpackage

// File: rtl/apb_interrupt_controller_if.sv
// APB register port plus interrupt request/acknowledge lines.
// Latency: n/a (wiring only).
// Backpressure: none; APB side is zero wait state, interrupt side waits on intr_serviced_i.
interface apb_interrupt_controller_if #(
  parameter int NUM_PERIPHS  = 16,
  parameter int ADDR_WIDTH   = $clog2(NUM_PERIPHS),
  parameter int DATA_WIDTH   = $clog2(NUM_PERIPHS),
  parameter int PERIPH_INDEX = $clog2(NUM_PERIPHS)
);
  logic [ADDR_WIDTH-1:0]   paddr_i;
  logic                    pwrite_i;
  logic [DATA_WIDTH-1:0]   pwdata_i;
  logic [DATA_WIDTH-1:0]   prdata_o;
  logic                    penable_i;
  logic                    pready_o;
  logic                    perror_o;
  logic                    intr_serviced_i;
  logic                    intr_valid_o;
  logic [PERIPH_INDEX-1:0] intr_to_service_o;
  logic [NUM_PERIPHS-1:0]  intr_active_i;

  modport slave (
    input  paddr_i, pwrite_i, pwdata_i, penable_i, intr_serviced_i, intr_active_i,
    output prdata_o, pready_o, perror_o, intr_valid_o, intr_to_service_o
  );

  modport master (
    output paddr_i, pwrite_i, pwdata_i, penable_i, intr_serviced_i, intr_active_i,
    input  prdata_o, pready_o, perror_o, intr_valid_o, intr_to_service_o
  );
endinterface

// File: rtl/apb_interrupt_controller_prio_arbiter.sv
// Picks the active source with the largest priority value, lowest index on ties.
// Latency: combinational.
// Backpressure: none.
module apb_interrupt_controller_prio_arbiter #(
  parameter int NUM_PERIPHS  = 16,
  parameter int DATA_WIDTH   = $clog2(NUM_PERIPHS),
  parameter int PERIPH_INDEX = $clog2(NUM_PERIPHS)
) (
  input  logic [NUM_PERIPHS-1:0]            i_active,
  input  logic [NUM_PERIPHS*DATA_WIDTH-1:0] i_prio_flat,
  output logic [PERIPH_INDEX-1:0]           o_idx,
  output logic                              o_any
);
  logic [DATA_WIDTH-1:0] w_best;
  logic                  w_found;

  // Linear max-search; strict '>' keeps the earlier (lower) index on a tie
  always_comb begin
    w_best  = '0;
    w_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NUM_PERIPHS; i++) begin
      if (i_active[i] && (!w_found || (i_prio_flat[i*DATA_WIDTH +: DATA_WIDTH] > w_best))) begin
        w_found = 1'b1;
        w_best  = i_prio_flat[i*DATA_WIDTH +: DATA_WIDTH];
        o_idx   = PERIPH_INDEX'(i);
      end
    end
    o_any = w_found;
  end
endmodule

// File: rtl/apb_interrupt_controller.sv
// Priority interrupt controller with an APB-programmable priority bank.
// Latency: APB access commits in 1 cycle; interrupt presented 1 cycle after request in idle.
// Backpressure: holds the presented interrupt until intr_serviced_i, then idles one cycle.
module apb_interrupt_controller
  import apb_interrupt_controller_pkg::*;
#(
  parameter int NUM_PERIPHS  = NUM_PERIPHS_DEF,
  parameter int ADDR_WIDTH   = $clog2(NUM_PERIPHS),
  parameter int DATA_WIDTH   = $clog2(NUM_PERIPHS),
  parameter int PERIPH_INDEX = $clog2(NUM_PERIPHS)
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  apb_interrupt_controller_if.slave     bus
);
  logic [DATA_WIDTH-1:0]           r_prio [NUM_PERIPHS];
  logic [DATA_WIDTH-1:0]           r_prdata;
  logic                            r_pready;
  logic                            r_perror;
  logic [0:0]                      r_state;
  logic                            r_valid;
  logic [PERIPH_INDEX-1:0]         r_idx;
  logic [ADDR_WIDTH-1:0]           w_addr;
  logic                            w_addr_ok;
  logic [NUM_PERIPHS*DATA_WIDTH-1:0] w_prio_flat;
  logic [PERIPH_INDEX-1:0]         w_win_idx;
  logic                            w_win_any;

  assign w_addr    = bus.paddr_i;
  assign w_addr_ok = (int'(w_addr) < NUM_PERIPHS);

  // Flatten the priority bank for the arbiter (registered values, so a same-cycle write is not seen)
  always_comb begin
    w_prio_flat = '0;
    for (int i = 0; i < NUM_PERIPHS; i++) begin
      w_prio_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_prio[i];
    end
  end

  apb_interrupt_controller_prio_arbiter #(
    .NUM_PERIPHS  (NUM_PERIPHS),
    .DATA_WIDTH   (DATA_WIDTH),
    .PERIPH_INDEX (PERIPH_INDEX)
  ) u_arb (
    .i_active    (bus.intr_active_i),
    .i_prio_flat (w_prio_flat),
    .o_idx       (w_win_idx),
    .o_any       (w_win_any)
  );

  // Zero-wait-state register access; out-of-range addresses flag an error and read 0
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      r_prdata <= '0;
      r_pready <= 1'b0;
      r_perror <= 1'b0;
      for (int i = 0; i < NUM_PERIPHS; i++) begin
        r_prio[i] <= '0;
      end
    end else if (bus.penable_i) begin
      r_pready <= 1'b1;
      if (w_addr_ok) begin
        r_perror <= 1'b0;
        if (bus.pwrite_i) begin
          r_prio[w_addr] <= bus.pwdata_i;
        end else begin
          r_prdata <= r_prio[w_addr];
        end
      end else begin
        r_perror <= 1'b1;
        r_prdata <= '0;
      end
    end else begin
      r_pready <= 1'b0;
      r_perror <= 1'b0;
    end
  end

  // Present one winner, hold it until acknowledged, then spend a cycle idle before re-arbitrating
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_any) begin
            r_idx   <= w_win_idx;
            r_valid <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          if (bus.intr_serviced_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.prdata_o          = r_prdata;
  assign bus.pready_o          = r_pready;
  assign bus.perror_o          = r_perror;
  assign bus.intr_valid_o      = r_valid;
  assign bus.intr_to_service_o = r_idx;
endmodule

// File: tb/tb_apb_interrupt_controller.sv
// Directed bench for apb_interrupt_controller: register access and arbitration order.
// Latency: stimulus driven 1ns after the rising edge, outputs sampled at the same point.
// Backpressure: interrupts are acknowledged one at a time by the bench.
module tb_apb_interrupt_controller;
  localparam int N = 16;

  logic pclk_i = 1'b0;
  logic prst_i = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  apb_interrupt_controller_if #(.NUM_PERIPHS(N)) bus ();

  apb_interrupt_controller #(.NUM_PERIPHS(N)) dut (
    .pclk_i (pclk_i),
    .prst_i (prst_i),
    .bus    (bus)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  // Back-to-back writes with penable held high
  task automatic write_prio(input logic [3:0] p [N]);
    bus.penable_i = 1'b1;
    bus.pwrite_i  = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.paddr_i  = 4'(i);
      bus.pwdata_i = p[i];
      tick();
      check_eq("wr_pready", 32'(bus.pready_o), 32'd1);
      check_eq("wr_perror", 32'(bus.perror_o), 32'd0);
    end
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    tick();
  endtask

  // Check the presented index, drop its request, acknowledge, confirm the idle gap
  task automatic serve(input int exp_idx);
    check_eq("valid_hi", 32'(bus.intr_valid_o), 32'd1);
    check_eq("idx", 32'(bus.intr_to_service_o), 32'(exp_idx));
    bus.intr_active_i[exp_idx] = 1'b0;
    bus.intr_serviced_i = 1'b1;
    tick();
    bus.intr_serviced_i = 1'b0;
    check_eq("valid_gap", 32'(bus.intr_valid_o), 32'd0);
    tick();
  endtask

  logic [3:0] prio [N];
  int         order [N];

  initial begin
    bus.paddr_i = '0; bus.pwrite_i = 1'b0; bus.pwdata_i = '0;
    bus.penable_i = 1'b0; bus.intr_serviced_i = 1'b0; bus.intr_active_i = '0;

    // Reset with random inputs
    for (int c = 0; c < 4; c++) begin
      bus.paddr_i = 4'($urandom_range(0, 15));
      bus.pwrite_i = 1'($urandom_range(0, 1));
      bus.pwdata_i = 4'($urandom_range(0, 15));
      bus.penable_i = 1'($urandom_range(0, 1));
      bus.intr_serviced_i = 1'($urandom_range(0, 1));
      bus.intr_active_i = 16'($urandom);
      tick();
      check_eq("rst_valid", 32'(bus.intr_valid_o), 32'd0);
      check_eq("rst_idx", 32'(bus.intr_to_service_o), 32'd0);
      check_eq("rst_pready", 32'(bus.pready_o), 32'd0);
      check_eq("rst_perror", 32'(bus.perror_o), 32'd0);
      check_eq("rst_prdata", 32'(bus.prdata_o), 32'd0);
    end
    bus.paddr_i = '0; bus.pwrite_i = 1'b0; bus.pwdata_i = '0;
    bus.penable_i = 1'b0; bus.intr_serviced_i = 1'b0; bus.intr_active_i = '0;
    prst_i = 1'b1;
    tick();

    // All priority registers read back 0 after reset
    bus.penable_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.paddr_i = 4'(i);
      tick();
      check_eq("rst_rd", 32'(bus.prdata_o), 32'd0);
    end
    bus.penable_i = 1'b0;
    tick();
    check_eq("idle_pready", 32'(bus.pready_o), 32'd0);

    // Write prio[i]=i, then read back
    for (int i = 0; i < N; i++) prio[i] = 4'(i);
    write_prio(prio);
    bus.penable_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.paddr_i = 4'(i);
      tick();
      check_eq("rd_data", 32'(bus.prdata_o), 32'(i));
      check_eq("rd_pready", 32'(bus.pready_o), 32'd1);
      check_eq("rd_perror", 32'(bus.perror_o), 32'd0);
    end
    bus.penable_i = 1'b0;
    tick();
    check_eq("rd_hold", 32'(bus.prdata_o), 32'd15);
    check_eq("rd_pready_lo", 32'(bus.pready_o), 32'd0);

    // Acknowledge while idle is ignored
    bus.intr_serviced_i = 1'b1;
    tick();
    bus.intr_serviced_i = 1'b0;
    check_eq("idle_ack", 32'(bus.intr_valid_o), 32'd0);

    // Ascending priority: 0x00A5 -> 7, 5, 2, 0
    bus.intr_active_i = 16'h00A5;
    tick();
    serve(7); serve(5); serve(2); serve(0);
    check_eq("asc_done", 32'(bus.intr_valid_o), 32'd0);

    // Descending priority: 0x8012 -> 1, 4, 15
    for (int i = 0; i < N; i++) prio[i] = 4'(15 - i);
    write_prio(prio);
    bus.intr_active_i = 16'h8012;
    tick();
    serve(1); serve(4); serve(15);
    check_eq("desc_done", 32'(bus.intr_valid_o), 32'd0);

    // Unique permutation: every index presented once, highest priority first
    for (int i = 0; i < N; i++) prio[i] = 4'((i * 7 + 3) % 16);
    for (int p = 0; p < N; p++)
      for (int i = 0; i < N; i++)
        if (int'(prio[i]) == 15 - p) order[p] = i;
    write_prio(prio);
    bus.intr_active_i = 16'hFFFF;
    tick();
    for (int p = 0; p < N; p++) serve(order[p]);
    check_eq("perm_done", 32'(bus.intr_valid_o), 32'd0);

    // Ties resolve to lowest index; presented index holds while waiting
    for (int i = 0; i < N; i++) prio[i] = 4'd3;
    write_prio(prio);
    bus.intr_active_i = 16'h0C00;
    tick();
    check_eq("tie_idx", 32'(bus.intr_to_service_o), 32'd10);
    bus.intr_active_i[15] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("hold_idx", 32'(bus.intr_to_service_o), 32'd10);
      check_eq("hold_valid", 32'(bus.intr_valid_o), 32'd1);
    end
    serve(10); serve(11); serve(15);
    check_eq("tie_done", 32'(bus.intr_valid_o), 32'd0);

    // Write during wait affects only the next arbitration
    bus.intr_active_i = 16'h0003;
    tick();
    check_eq("pre_wr_idx", 32'(bus.intr_to_service_o), 32'd0);
    bus.penable_i = 1'b1; bus.pwrite_i = 1'b1; bus.paddr_i = 4'd1; bus.pwdata_i = 4'd9;
    tick();
    bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    check_eq("wait_idx", 32'(bus.intr_to_service_o), 32'd0);
    bus.intr_active_i[0] = 1'b0;
    bus.intr_serviced_i = 1'b1;
    bus.intr_active_i[0] = 1'b1;
    tick();
    bus.intr_serviced_i = 1'b0;
    tick();
    check_eq("post_wr_idx", 32'(bus.intr_to_service_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
